// File: rtl/bf_bus_responder.sv
// rtl/bf_bus_responder.sv - BF chip bus responder: phase-sequenced memory and stream access
// Collects opcode/address/data over chip phases 1..4, executes one access, then strobes op_done.
module bf_bus_responder #(
  parameter int ADDR_W = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        chip_bus,
  input  logic [2:0]        chip_phase,
  input  logic              chip_halted,
  output logic [7:0]        resp_bus,
  output logic              op_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              proto_err,
  output logic              busy
);

  typedef enum logic [3:0] {
    IDLE, GOT_OP, GOT_HI, GOT_ADDR, EXEC, WAIT_MEM, WAIT_IO, DONE, DRAIN
  } state_t;

  localparam logic [2:0] PH_OP = 3'd1;
  localparam logic [2:0] PH_HI = 3'd2;
  localparam logic [2:0] PH_LO = 3'd3;
  localparam logic [2:0] PH_RW = 3'd4;

  localparam logic [2:0] OP_PROG_RD = 3'd1;
  localparam logic [2:0] OP_DATA_RD = 3'd2;
  localparam logic [2:0] OP_DATA_WR = 3'd3;
  localparam logic [2:0] OP_IN_RD   = 3'd4;
  localparam logic [2:0] OP_OUT_WR  = 3'd5;

  state_t     state, state_next;
  logic [2:0] opcode;
  logic       op_load, hi_load, lo_load, wd_load;
  logic       start_mem, start_out, set_err, resp_load;
  logic [7:0] resp_val, rd_sel;
  logic       checked, phase_ok, drain_needed, is_mem_op;

  assign is_mem_op    = (opcode == OP_PROG_RD) || (opcode == OP_DATA_RD) || (opcode == OP_DATA_WR);
  assign drain_needed = (mem_req && !mem_ack) || (out_valid && !out_ready);
  assign rd_sel       = (opcode == OP_DATA_WR) ? 8'h00 : mem_rdata;
  assign op_done      = (state == DONE);
  assign busy         = (state != IDLE);

  // Accepted phases per state: the expected one, or the previous one still being held.
  always_comb begin
    checked  = 1'b1;
    phase_ok = 1'b0;
    case (state)
      GOT_OP:                  phase_ok = (chip_phase == PH_OP) || (chip_phase == PH_HI);
      GOT_HI:                  phase_ok = (chip_phase == PH_HI) || (chip_phase == PH_LO);
      GOT_ADDR:                phase_ok = (chip_phase == PH_LO) || (chip_phase == PH_RW);
      EXEC, WAIT_MEM, WAIT_IO: phase_ok = (chip_phase == PH_RW);
      default:                 checked  = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    op_load    = 1'b0;
    hi_load    = 1'b0;
    lo_load    = 1'b0;
    wd_load    = 1'b0;
    start_mem  = 1'b0;
    start_out  = 1'b0;
    set_err    = 1'b0;
    resp_load  = 1'b0;
    resp_val   = 8'h00;
    in_ready   = 1'b0;
    if (checked && (chip_halted || !phase_ok)) begin
      set_err    = 1'b1;
      state_next = drain_needed ? DRAIN : IDLE;
    end else begin
      case (state)
        IDLE: if (!chip_halted && chip_phase == PH_OP) begin
          op_load    = 1'b1;
          state_next = GOT_OP;
        end
        GOT_OP: if (chip_phase == PH_HI) begin
          hi_load    = 1'b1;
          state_next = GOT_HI;
        end
        GOT_HI: if (chip_phase == PH_LO) begin
          lo_load    = 1'b1;
          state_next = GOT_ADDR;
        end
        // mem_req is raised on entry to EXEC so an immediate ack can finish there.
        GOT_ADDR: if (chip_phase == PH_RW) begin
          wd_load    = 1'b1;
          start_mem  = is_mem_op;
          state_next = EXEC;
        end
        EXEC: begin
          if (is_mem_op) begin
            if (mem_ack) begin
              resp_load  = 1'b1;
              resp_val   = rd_sel;
              state_next = DONE;
            end else begin
              state_next = WAIT_MEM;
            end
          end else if (opcode == OP_IN_RD) begin
            state_next = WAIT_IO;
          end else if (opcode == OP_OUT_WR) begin
            start_out  = 1'b1;
            state_next = WAIT_IO;
          end else begin
            set_err    = 1'b1;
            resp_load  = 1'b1;
            state_next = DONE;
          end
        end
        WAIT_MEM: if (mem_ack) begin
          resp_load  = 1'b1;
          resp_val   = rd_sel;
          state_next = DONE;
        end
        WAIT_IO: begin
          if (opcode == OP_IN_RD) begin
            if (in_valid) begin
              in_ready   = 1'b1;
              resp_load  = 1'b1;
              resp_val   = in_data;
              state_next = DONE;
            end
          end else if (out_valid && out_ready) begin
            resp_load  = 1'b1;
            state_next = DONE;
          end
        end
        DONE:    state_next = IDLE;
        DRAIN:   if (!drain_needed) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      opcode    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      resp_bus  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (op_load) opcode <= chip_bus[2:0];
      if (hi_load) mem_addr[ADDR_W-1:8] <= chip_bus[ADDR_W-9:0];
      if (lo_load) mem_addr[7:0] <= chip_bus;
      if (wd_load) mem_wdata <= chip_bus;
      if (start_mem) begin
        mem_req <= 1'b1;
        mem_we  <= (opcode == OP_DATA_WR);
      end else if (mem_req && mem_ack) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
      if (start_out) begin
        out_valid <= 1'b1;
        out_data  <= mem_wdata;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (resp_load) resp_bus <= resp_val;
      if (set_err) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bf_bus_responder.sv
// tb/tb_bf_bus_responder.sv - randomized scoreboard bench for bf_bus_responder
module tb_bf_bus_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  chip_bus = 8'h00;
  logic [2:0]  chip_phase = 3'd0;
  logic        chip_halted = 1'b0;
  logic [7:0]  resp_bus;
  logic        op_done;
  logic        mem_req, mem_we;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        proto_err, busy;

  bf_bus_responder #(.ADDR_W(15)) dut (
    .clock(clock), .reset(reset), .chip_bus(chip_bus), .chip_phase(chip_phase),
    .chip_halted(chip_halted), .resp_bus(resp_bus), .op_done(op_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .proto_err(proto_err), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [14:0] addr;
    logic [7:0]  wd;
  } mem_exp_t;

  mem_exp_t   exp_mem[$];
  logic [7:0] exp_resp[$];
  logic [7:0] exp_out[$];
  logic [7:0] in_q[$];
  logic [7:0] ref_mem[0:32767];
  logic [7:0] mem_store[0:32767];

  int vectors = 0;
  int miscompares = 0;
  bit exp_err = 1'b0;
  int ack_mode = 0;   // 0 delayed ack, 1 ack tied high, 2 ack withheld
  int fixed_dly = -1;
  int in_gap = 0;
  int out_dly = 0;
  int in_pulses = 0;
  int ov_run = 0;
  int last_ov_run = 0;
  bit in_taken = 1'b0;
  bit prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event occurred, none expected", name);
  endtask

  // Monitor / scoreboard
  initial forever begin
    @(negedge clock);
    if (reset) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) begin
        check("op_done_single", op_done, 0);
        check("idle_after_done", busy, 0);
      end
      prev_done = op_done;
      if (op_done) begin
        if (exp_resp.size() == 0) flag("unexpected_op_done");
        else begin
          check("resp_bus", resp_bus, exp_resp.pop_front());
          check("proto_err_at_done", proto_err, exp_err);
        end
      end
      if (mem_req) begin
        if (mem_ack && mem_we) mem_store[mem_addr] = mem_wdata;
        if (exp_mem.size() == 0) flag("unexpected_mem_req");
        else begin
          check("mem_addr", mem_addr, exp_mem[0].addr);
          check("mem_we", mem_we, exp_mem[0].we);
          if (exp_mem[0].we) check("mem_wdata", mem_wdata, exp_mem[0].wd);
          if (mem_ack) exp_mem.delete(0);
        end
      end
      if (out_valid) begin
        ov_run++;
        if (exp_out.size() == 0) flag("unexpected_out_valid");
        else check("out_data", out_data, exp_out[0]);
        if (out_ready) begin
          last_ov_run = ov_run;
          ov_run = 0;
          if (exp_out.size() > 0) exp_out.delete(0);
        end
      end else begin
        ov_run = 0;
      end
      if (in_ready) begin
        in_pulses++;
        in_taken = 1'b1;
      end
    end
  end

  // Memory responder
  initial begin : mem_model
    int cnt;
    int dly;
    cnt = 0;
    dly = 0;
    forever begin
      @(posedge clock); #1;
      if (ack_mode == 1) mem_ack = 1'b1;
      else if (ack_mode == 0 && mem_req) begin
        if (cnt == 0) dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
        mem_ack = (cnt >= dly);
        cnt++;
      end else mem_ack = 1'b0;
      if (!mem_req) cnt = 0;
      mem_rdata = mem_store[mem_addr];
    end
  end

  // Input stream source
  initial forever begin
    @(posedge clock); #1;
    if (in_valid && in_taken) begin
      in_valid = 1'b0;
      in_taken = 1'b0;
    end
    if (!in_valid && in_q.size() > 0) begin
      if (in_gap > 0) in_gap--;
      else begin
        in_valid = 1'b1;
        in_data  = in_q.pop_front();
      end
    end
  end

  // Output stream sink
  initial begin : sink
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clock); #1;
      if (out_valid) begin
        out_ready = (cnt >= out_dly);
        cnt++;
      end else begin
        out_ready = 1'b0;
        cnt = 0;
      end
    end
  end

  task automatic drive(input logic [2:0] ph, input logic [7:0] b, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock); #1;
      chip_phase = ph;
      chip_bus   = b;
    end
  endtask

  task automatic issue(input int op, input int addr, input logic [7:0] wd, input bit rnd);
    logic [14:0] a;
    logic [7:0]  ob, hb;
    a  = addr[14:0];
    ob = {rnd ? 5'($urandom) : 5'd0, 3'(op)};
    hb = {rnd ? 1'($urandom) : 1'b0, a[14:8]};
    case (op)
      1, 2: begin
        exp_mem.push_back('{1'b0, a, 8'h00});
        exp_resp.push_back(ref_mem[a]);
      end
      3: begin
        exp_mem.push_back('{1'b1, a, wd});
        ref_mem[a] = wd;
        exp_resp.push_back(8'h00);
      end
      4: exp_resp.push_back(wd);
      5: begin
        exp_out.push_back(wd);
        exp_resp.push_back(8'h00);
      end
      default: begin
        exp_err = 1'b1;
        exp_resp.push_back(8'h00);
      end
    endcase
    drive(3'd1, ob, rnd ? int'($urandom_range(1, 2)) : 1);
    drive(3'd2, hb, rnd ? int'($urandom_range(1, 2)) : 1);
    drive(3'd3, a[7:0], rnd ? int'($urandom_range(1, 2)) : 1);
    @(posedge clock); #1;
    chip_phase = 3'd4;
    chip_bus   = wd;
    if (op == 4) in_q.push_back(wd);
  endtask

  task automatic do_txn(input int op, input int addr, input logic [7:0] wd, input bit rnd, output int lat);
    issue(op, addr, wd, rnd);
    lat = 0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clock);
      if (op_done) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) flag("op_done_timeout");
    @(posedge clock); #1;
    chip_phase = 3'd0;
    chip_bus   = 8'($urandom);
  endtask

  initial begin : main
    int lat;
    int p0;
    int waited;
    for (int a = 0; a < 32768; a++) begin
      ref_mem[a]   = 8'(a ^ (a >> 7) ^ 8'h5A);
      mem_store[a] = ref_mem[a];
    end

    repeat (3) @(posedge clock);
    #1;
    check("reset_data", {resp_bus, mem_wdata, out_data}, 0);
    check("reset_ctrl", {op_done, mem_req, mem_we, in_ready, out_valid, proto_err, busy}, 0);
    check("reset_addr", mem_addr, 0);
    reset = 1'b0;

    // Data-write with a 2-cycle ack delay
    ack_mode = 0; fixed_dly = 2;
    do_txn(3, 'h1234, 8'hAB, 1'b0, lat);

    // Prog-read at the top address with ack tied high: minimum latency
    ack_mode = 1;
    ref_mem['h7FFF] = 8'h5C;
    mem_store['h7FFF] = 8'h5C;
    do_txn(1, 'h7FFF, 8'h00, 1'b0, lat);
    check("prog_read_latency", lat, 3);

    // In-read with a late source
    in_gap = 5;
    p0 = in_pulses;
    do_txn(4, 'h0100, 8'h41, 1'b0, lat);
    check("in_ready_pulses", in_pulses - p0, 1);

    // Out-write with a slow sink
    out_dly = 3;
    do_txn(5, 'h0200, 8'h0A, 1'b0, lat);
    check("out_valid_cycles", last_ov_run, 4);

    // Halted chip in IDLE is ignored
    chip_halted = 1'b1;
    drive(3'd1, 8'h02, 3);
    @(negedge clock);
    check("halted_stays_idle", busy, 0);
    check("halted_no_err", proto_err, 0);
    chip_halted = 1'b0;
    chip_phase  = 3'd0;

    // Abort during WAIT_MEM: request drains, no op_done
    ack_mode = 2;
    exp_mem.push_back('{1'b0, 15'h0456, 8'h00});
    exp_err = 1'b1;
    drive(3'd1, 8'h02, 1);
    drive(3'd2, 8'h04, 1);
    drive(3'd3, 8'h56, 1);
    drive(3'd4, 8'h00, 3);
    chip_phase = 3'd0;
    repeat (4) begin
      @(negedge clock);
      check("abort_req_held", mem_req, 1);
    end
    ack_mode = 0; fixed_dly = 0;
    waited = 0;
    for (int n = 0; n < 20 && busy; n++) begin
      @(negedge clock);
      waited++;
    end
    check("abort_back_idle", busy, 0);
    check("abort_proto_err", proto_err, 1);

    // Illegal opcode still completes
    do_txn(7, 'h0000, 8'h00, 1'b0, lat);

    // Reset while waiting on the output stream
    out_dly = 1000;
    issue(5, 'h0300, 8'h77, 1'b0);
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clock);
    check("rst_out_pending", out_valid, 1);
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_proto_err", proto_err, 0);
    exp_out.delete();
    exp_resp.delete();
    exp_mem.delete();
    exp_err = 1'b0;
    out_dly = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    chip_phase = 3'd0;
    do_txn(3, 'h0300, 8'hC3, 1'b0, lat);
    do_txn(2, 'h0300, 8'h00, 1'b0, lat);

    // Randomized traffic
    fixed_dly = -1;
    for (int i = 0; i < 80; i++) begin
      int op;
      int addr;
      int r;
      r = $urandom_range(0, 99);
      op = (r < 90) ? int'($urandom_range(1, 5)) : ((r < 94) ? 0 : int'($urandom_range(6, 7)));
      addr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 32767)) : 'h0040 + int'($urandom_range(0, 7));
      ack_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
      in_gap = $urandom_range(0, 4);
      out_dly = $urandom_range(0, 4);
      do_txn(op, addr, 8'($urandom), 1'b1, lat);
    end

    repeat (5) @(posedge clock);
    check("resp_queue_drained", exp_resp.size(), 0);
    check("mem_queue_drained", exp_mem.size(), 0);
    check("out_queue_drained", exp_out.size(), 0);
    check("final_proto_err", proto_err, exp_err);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bf_bus_responder.md
BF_BUS_RESPONDER -- requirements
Module: bf_bus_responder

Interface
REQ-001 Parameter: ADDR_W, default 15, width of the latched bus address.
REQ-002 clock  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 chip_bus  input  8  byte driven by the BF chip.
REQ-005 chip_phase  input  3  chip bus phase: 0 none, 1 opcode, 2 addr-hi, 3 addr-lo, 4 read/write.
REQ-006 chip_halted  input  1  chip halted flag.
REQ-007 resp_bus  output  8  byte returned to the chip.
REQ-008 op_done  output  1  single-cycle completion strobe to the chip.
REQ-009 mem_req, mem_we  output  1 each  memory request and write-enable.
REQ-010 mem_addr  output  ADDR_W  memory address.
REQ-011 mem_wdata  output  8  memory write data.
REQ-012 mem_ack  input  1  memory accept; completes the request in the same cycle.
REQ-013 mem_rdata  input  8  memory read data, valid when mem_ack=1.
REQ-014 in_data  input  8  and in_valid  input  1  input stream; in_ready  output  1  consume strobe.
REQ-015 out_data  output  8  and out_valid  output  1  output stream; out_ready  input  1  sink accept.
REQ-016 proto_err  output  1  sticky protocol-error flag.
REQ-017 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-018 Opcode field: chip_bus[2:0]; 0 none, 1 prog-read, 2 data-read, 3 data-write, 4 in-read, 5 out-write; 6 and 7 are illegal.
REQ-019 FSM states: IDLE, GOT_OP, GOT_HI, GOT_ADDR, EXEC, WAIT_MEM, WAIT_IO, DONE, DRAIN.
REQ-020 IDLE with chip_phase=1: latch opcode, go to GOT_OP.
REQ-021 GOT_OP with chip_phase=2: latch addr[ADDR_W-1:8]=chip_bus[ADDR_W-9:0], go to GOT_HI.
REQ-022 GOT_HI with chip_phase=3: latch addr[7:0], go to GOT_ADDR.
REQ-023 GOT_ADDR with chip_phase=4: latch chip_bus as write data, go to EXEC.
REQ-024 EXEC for opcodes 1, 2 and 3: assert mem_req, with mem_we=1 only for opcode 3; mem_addr = latched address; go to WAIT_MEM.
REQ-025 WAIT_MEM: hold mem_req, mem_we, mem_addr and mem_wdata stable until mem_ack; on mem_ack, register mem_rdata (read ops only) and go to DONE.
REQ-026 EXEC for opcode 4: go to WAIT_IO.
REQ-027 WAIT_IO for opcode 4: on in_valid, register in_data, pulse in_ready for 1 cycle, go to DONE.
REQ-028 EXEC for opcode 5: set out_data = write data and out_valid=1, go to WAIT_IO.
REQ-029 WAIT_IO for opcode 5: hold out_valid and out_data until out_ready, then clear out_valid and go to DONE.
REQ-030 DONE: op_done=1 for exactly one cycle, with resp_bus = registered read data (0 for write ops); then go to IDLE.
REQ-031 resp_bus holds its value outside DONE; op_done is 0 in every state except DONE.
REQ-032 Minimum latency: with mem_ack tied high, op_done is high on the 3rd cycle of chip phase 4.
REQ-033 Illegal opcode (6 or 7) or opcode 0 in EXEC: set proto_err and go to DONE with resp_bus=0, so the chip is not deadlocked.
REQ-034 Phase out of sequence in any non-IDLE state: set proto_err; go to DRAIN if mem_req or out_valid is outstanding, otherwise go to IDLE.
REQ-035 Phase out of sequence covers: chip_phase=0 while waiting, or any phase value other than the expected one.
REQ-036 Phase value equal to the previous phase: not an error; hold the current state.
REQ-037 DRAIN: keep mem_req until mem_ack and out_valid until out_ready; suppress op_done; then go to IDLE.
REQ-038 chip_halted=1 while in IDLE: stay in IDLE and ignore chip_phase.
REQ-039 chip_halted=1 in any other state: treat as an out-of-sequence phase per REQ-034.
REQ-040 proto_err clears only on reset.

Reset
REQ-041 On reset assertion, asynchronously: state=IDLE, resp_bus=0, op_done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, in_ready=0, out_valid=0, out_data=0, proto_err=0, busy=0.
REQ-042 Reset mid-operation abandons any outstanding memory or stream handshake without completing it.
REQ-043 Operation resumes on the first rising clock edge after reset deasserts.

Verification
REQ-044 Data-write: phases 1/2/3/4 with bytes 0x03/0x12/0x34/0xAB, mem_ack after 2 cycles -> mem_addr=0x1234, mem_we=1, mem_wdata=0xAB; one op_done pulse; resp_bus=0x00.
REQ-045 Prog-read: opcode 1, address 0x7FFF, mem_ack tied high, mem_rdata=0x5C -> op_done on 3rd phase-4 cycle with resp_bus=0x5C; busy=0 next cycle.
REQ-046 In-read: opcode 4, in_valid low for 5 cycles, then in_data=0x41 -> single-cycle in_ready, op_done with resp_bus=0x41, chip held in phase 4 during wait.
REQ-047 Out-write: opcode 5, data 0x0A, out_ready after 3 cycles -> out_valid high 4 cycles with out_data=0x0A, then op_done pulse.
REQ-048 Abort/illegal: chip_phase drops to 0 during WAIT_MEM -> mem_req held until mem_ack, no op_done, proto_err=1; opcode 7 -> op_done with resp_bus=0 and proto_err=1.
REQ-049 Reset pulse during WAIT_IO (opcode 5) -> out_valid=0 and state IDLE immediately; the next full transaction completes normally.
